// File: rtl/mcu_trace_buffer.sv
// mcu_trace_buffer: captures MCU I/O and interrupt events into a circular trace RAM.
// An address trigger starts a post-trigger countdown, after which the buffer freezes.
// The frozen trace is read back oldest-first through a 1-cycle-latency read port.
module mcu_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int POST  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          trig_en,
    input  logic [11:0]   trig_addr,
    input  logic [11:0]   address,
    input  logic [7:0]    port_id,
    input  logic [7:0]    out_port,
    input  logic [7:0]    in_port,
    input  logic          write_strobe,
    input  logic          read_strobe,
    input  logic          interrupt_ack,
    output logic [1:0]    state,
    output logic          done,
    output logic [AW:0]   count,
    output logic          wrapped,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [31:0]   rd_data
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_ARMED    = 2'b01,
        S_POSTTRIG = 2'b10,
        S_DONE     = 2'b11
    } state_t;

    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_INIT = AW'(POST);

    // Entry type codes stored in bits [31:30]
    localparam logic [1:0] T_WRITE = 2'b00;
    localparam logic [1:0] T_READ  = 2'b01;
    localparam logic [1:0] T_IACK  = 2'b10;
    localparam logic [1:0] T_TRIG  = 2'b11;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          wrapped_q, wrapped_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic          done_q;
    logic          rd_valid_q;
    logic [31:0]   rd_data_q;

    logic [31:0]   trace_mem [DEPTH];

    logic [1:0]    ev_cnt;
    logic          any_event;
    logic          collision;
    logic          trig_hit;
    logic          capture_en;
    logic [31:0]   entry_d;
    logic [AW-1:0] rd_addr;
    logic          rd_in_range;

    // Decode events of this cycle and build the entry that would be captured
    always_comb begin
        ev_cnt     = 2'(write_strobe) + 2'(read_strobe) + 2'(interrupt_ack);
        any_event  = (ev_cnt != 2'd0);
        collision  = (ev_cnt > 2'd1);
        trig_hit   = (state_q == S_ARMED) && trig_en && (address == trig_addr);
        // The arm cycle itself never records anything
        capture_en = !arm && ((state_q == S_ARMED) || (state_q == S_POSTTRIG))
                     && (any_event || trig_hit);

        // Default is a trigger-only marker; strobes override in priority order
        entry_d = {T_TRIG, address, trig_hit, collision, 8'h00, 8'h00};
        if (write_strobe) begin
            entry_d = {T_WRITE, address, trig_hit, collision, port_id, out_port};
        end else if (read_strobe) begin
            entry_d = {T_READ, address, trig_hit, collision, port_id, in_port};
        end else if (interrupt_ack) begin
            entry_d = {T_IACK, address, trig_hit, collision, 8'h00, 8'h00};
        end
    end

    // Next-state logic for the capture FSM, write pointer and fill level
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        wrapped_d  = wrapped_q;
        post_cnt_d = post_cnt_q;

        if (arm) begin
            state_d    = S_ARMED;
            count_d    = '0;
            wr_ptr_d   = '0;
            wrapped_d  = 1'b0;
            post_cnt_d = '0;
        end else begin
            if (capture_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (count_q == FULL) begin
                    wrapped_d = 1'b1;
                end else begin
                    count_d = count_q + (AW+1)'(1);
                end
            end

            case (state_q)
                S_ARMED: begin
                    if (trig_hit) begin
                        if (POST == 0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_POSTTRIG;
                            post_cnt_d = POST_INIT;
                        end
                    end
                end
                S_POSTTRIG: begin
                    if (capture_en) begin
                        post_cnt_d = post_cnt_q - AW'(1);
                        if (post_cnt_q <= AW'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control state registers; done is registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            wrapped_q  <= 1'b0;
            post_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            wrapped_q  <= wrapped_d;
            post_cnt_q <= post_cnt_d;
            done_q     <= (state_d == S_DONE);
        end
    end

    // Trace RAM write port
    always_ff @(posedge clk) begin
        if (capture_en) begin
            trace_mem[wr_ptr_q] <= entry_d;
        end
    end

    // Oldest entry lives at wr_ptr - count (mod DEPTH); indices past the fill level read as zero
    always_comb begin
        rd_addr     = wr_ptr_q - count_q[AW-1:0] + rd_idx;
        rd_in_range = ({1'b0, rd_idx} < count_q);
    end

    // Registered read port; RAM read-before-write returns old data on a same-slot write
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_in_range ? trace_mem[rd_addr] : 32'h0;
            end
        end
    end

    assign state    = state_q;
    assign done     = done_q;
    assign count    = count_q;
    assign wrapped  = wrapped_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule
